// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_ctrl
// Description : Raster-stream window tracker; flags pixels completing a KxK
//               window under a given stride, with start/done frame framing.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module conv_window_ctrl #(
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int KERNEL_SIZE  = 5,
  parameter int STRIDE       = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  output logic             o_busy,
  output logic             o_enable,
  output logic [CNT_W-1:0] o_out_row,
  output logic [CNT_W-1:0] o_out_col,
  output logic             o_frame_done
);

  localparam logic [CNT_W-1:0] c_W_LAST = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_W-1:0] c_K_LAST = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] c_S_LAST = CNT_W'(STRIDE - 1);
  localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_in_col;
  logic [CNT_W-1:0] r_in_row;
  logic [CNT_W-1:0] r_col_phase;
  logic [CNT_W-1:0] r_row_phase;
  logic [CNT_W-1:0] r_ocol_cnt;
  logic [CNT_W-1:0] r_orow_cnt;
  logic             r_enable;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_out_row;
  logic [CNT_W-1:0] r_out_col;

  logic w_accept;
  logic w_row_ok;
  logic w_col_ok;
  logic w_row_end;
  logic w_last;
  logic w_window;

  assign w_accept  = (r_state == S_STREAM) && i_pix_valid;
  assign w_row_ok  = (r_in_row >= c_K_LAST);
  assign w_col_ok  = (r_in_col >= c_K_LAST);
  assign w_row_end = (r_in_col == c_W_LAST);
  assign w_last    = w_row_end && (r_in_row == c_H_LAST);
  // Phase zero on both axes marks a stride-aligned window position.
  assign w_window  = w_row_ok && w_col_ok && (r_row_phase == '0) && (r_col_phase == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_in_col     <= '0;
      r_in_row     <= '0;
      r_col_phase  <= '0;
      r_row_phase  <= '0;
      r_ocol_cnt   <= '0;
      r_orow_cnt   <= '0;
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
    end else begin
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_col_phase <= '0;
            r_row_phase <= '0;
            r_ocol_cnt  <= '0;
            r_orow_cnt  <= '0;
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            if (w_window) begin
              r_enable   <= 1'b1;
              r_out_row  <= r_orow_cnt;
              r_out_col  <= r_ocol_cnt;
              r_ocol_cnt <= r_ocol_cnt + c_ONE;
            end
            if (w_col_ok) begin
              r_col_phase <= (r_col_phase == c_S_LAST) ? '0 : r_col_phase + c_ONE;
            end
            if (w_row_end) begin
              r_in_col    <= '0;
              r_in_row    <= r_in_row + c_ONE;
              r_col_phase <= '0;
              r_ocol_cnt  <= '0;
              // Output row advances only after a row that produced windows.
              if (w_row_ok) begin
                r_row_phase <= (r_row_phase == c_S_LAST) ? '0 : r_row_phase + c_ONE;
                if (r_row_phase == '0) begin
                  r_orow_cnt <= r_orow_cnt + c_ONE;
                end
              end
            end else begin
              r_in_col <= r_in_col + c_ONE;
            end
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pix_ready  = (r_state == S_STREAM);
  assign o_busy       = (r_state != S_IDLE);
  assign o_enable     = r_enable;
  assign o_frame_done = r_frame_done;
  assign o_out_row    = r_out_row;
  assign o_out_col    = r_out_col;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_ctrl
// Description : Randomised self-checking bench for conv_window_ctrl over
//               several image/kernel/stride configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;

  localparam int c_NDUT = 3;

  function automatic int f_w(input int i);
    case (i)
      0: return 28;
      1: return 8;
      default: return 10;
    endcase
  endfunction
  function automatic int f_h(input int i);
    case (i)
      0: return 28;
      1: return 8;
      default: return 6;
    endcase
  endfunction
  function automatic int f_k(input int i);
    case (i)
      0: return 5;
      default: return 3;
    endcase
  endfunction
  function automatic int f_s(input int i);
    case (i)
      1: return 2;
      default: return 1;
    endcase
  endfunction

  logic                  clk;
  logic                  rst;
  logic [c_NDUT-1:0]     start;
  logic [c_NDUT-1:0]     valid;
  logic [c_NDUT-1:0]     ready;
  logic [c_NDUT-1:0]     busy;
  logic [c_NDUT-1:0]     en;
  logic [c_NDUT-1:0]     fd;
  logic [c_NDUT-1:0][7:0] orow;
  logic [c_NDUT-1:0][7:0] ocol;

  int n_checks;
  int n_errors;
  int exp_or [c_NDUT];
  int exp_oc [c_NDUT];

  for (genvar g = 0; g < c_NDUT; g++) begin : g_dut
    conv_window_ctrl #(
      .IMAGE_WIDTH (f_w(g)),
      .IMAGE_HEIGHT(f_h(g)),
      .KERNEL_SIZE (f_k(g)),
      .STRIDE      (f_s(g)),
      .CNT_W       (8)
    ) u_dut (
      .clk         (clk),
      .reset       (rst),
      .i_start     (start[g]),
      .i_pix_valid (valid[g]),
      .o_pix_ready (ready[g]),
      .o_busy      (busy[g]),
      .o_enable    (en[g]),
      .o_out_row   (orow[g]),
      .o_out_col   (ocol[g]),
      .o_frame_done(fd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic t_check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic t_clear_model();
    for (int i = 0; i < c_NDUT; i++) begin
      exp_or[i] = 0;
      exp_oc[i] = 0;
    end
  endtask

  // Runs one frame on DUT d. duty = percent of cycles with pix_valid high.
  // rst_at >= 0 aborts the frame with an async reset once that many pixels are in.
  task automatic run_frame(input int d, input int duty, input int rst_at, input bit poke_start);
    int  w, h, k, s, n_acc, n_en, n_busy, iter, r, c;
    bit  v, exp_e, done, aborted;
    w = f_w(d); h = f_h(d); k = f_k(d); s = f_s(d);
    n_acc = 0; n_en = 0; iter = 0; done = 0; aborted = 0;

    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    n_busy = busy[d];
    t_check("stream_ready", ready[d], 1);
    t_check("stream_busy", busy[d], 1);

    while (!done) begin
      v = ($urandom_range(99) < duty);
      valid[d] = v;
      if (poke_start) start[d] = 1'($urandom_range(1));
      if (rst_at >= 0 && n_acc == rst_at) begin
        valid[d] = 1'b0;
        start[d] = 1'b0;
        #2 rst = 1'b1;
        #1;
        t_check("rst_enable", en[d], 0);
        t_check("rst_frame_done", fd[d], 0);
        t_check("rst_out_row", orow[d], 0);
        t_check("rst_out_col", ocol[d], 0);
        t_check("rst_busy", busy[d], 0);
        t_check("rst_ready", ready[d], 0);
        t_clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        t_check("post_rst_frame_done", fd[d], 0);
        t_check("post_rst_busy", busy[d], 0);
        done = 1; aborted = 1;
      end else begin
        @(posedge clk); #1;
        iter++;
        n_busy += int'(busy[d]);
        exp_e = 1'b0;
        if (v) begin
          r = n_acc / w;
          c = n_acc % w;
          if (r >= k - 1 && c >= k - 1 && (r - k + 1) % s == 0 && (c - k + 1) % s == 0) begin
            exp_e = 1'b1;
            exp_or[d] = (r - k + 1) / s;
            exp_oc[d] = (c - k + 1) / s;
          end
          n_acc++;
        end
        if (en[d]) n_en++;
        t_check("enable", en[d], exp_e);
        t_check("out_row", orow[d], exp_or[d]);
        t_check("out_col", ocol[d], exp_oc[d]);
        t_check("frame_done", fd[d], (v && n_acc == w * h) ? 1 : 0);
        if (v && n_acc == w * h) done = 1;
        if (iter > 20000) begin
          t_check("frame_timeout", iter, 20000);
          done = 1; aborted = 1;
        end
      end
    end

    if (!aborted) begin
      start[d] = 1'b0;
      valid[d] = 1'b1;
      t_check("done_busy", busy[d], 1);
      t_check("done_ready", ready[d], 0);
      if (duty >= 100) t_check("busy_cycles", n_busy, w * h + 1);
      t_check("enable_count", n_en, ((w - k) / s + 1) * ((h - k) / s + 1));
      @(posedge clk); #1;
      t_check("idle_enable", en[d], 0);
      t_check("idle_frame_done", fd[d], 0);
      t_check("idle_busy", busy[d], 0);
      t_check("idle_ready", ready[d], 0);
      valid[d] = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = '0;
    valid = '0;
    t_clear_model();
    repeat (2) @(posedge clk);
    #1;
    t_check("reset_enable", en[0], 0);
    t_check("reset_frame_done", fd[0], 0);
    t_check("reset_out_row", orow[0], 0);
    t_check("reset_out_col", ocol[0], 0);
    t_check("reset_busy", busy[0], 0);
    rst = 1'b0;

    // pix_valid while idle must be ignored
    valid[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      t_check("idle_valid_ready", ready[0], 0);
      t_check("idle_valid_enable", en[0], 0);
    end
    valid[0] = 1'b0;

    run_frame(0, 100, -1, 1'b0);
    run_frame(1, 100, -1, 1'b0);
    run_frame(0, 50, -1, 1'b0);
    run_frame(2, 100, -1, 1'b1);
    run_frame(2, 60, -1, 1'b0);
    run_frame(0, 100, 300, 1'b0);
    run_frame(0, 100, -1, 1'b1);
    run_frame(1, 40, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Parametrised control FSM for the streaming convolver datapath. Successor to the fixed 28x28 / 5x5 enable generator.
- Accepts a raster-order pixel stream through a valid/ready handshake. Tracks the input row and column, and flags each accepted pixel that completes a valid KERNEL_SIZE x KERNEL_SIZE window.
- Supports arbitrary stride, rectangular images, input stalls, and start/done framing.
- Sits between the pixel source and the line-buffer/MAC datapath. Its `enable` qualifies MAC output writes.

Parameters:
- IMAGE_WIDTH, 28, input columns per row (>= KERNEL_SIZE).
- IMAGE_HEIGHT, 28, input rows per frame (>= KERNEL_SIZE).
- KERNEL_SIZE, 5, square kernel dimension (>= 1).
- STRIDE, 1, window step in both axes (>= 1, <= KERNEL_SIZE).
- CNT_W, 8, counter width. Must hold max(IMAGE_WIDTH, IMAGE_HEIGHT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- pix_valid  in  1  source has a pixel this cycle.
- pix_ready  out  1  block accepts pixels (high only in STREAM).
- busy  out  1  frame in progress (STREAM or DONE).
- enable  out  1  registered: previously accepted pixel completed a valid window.
- out_row  out  CNT_W  output-map row index of the window flagged by enable.
- out_col  out  CNT_W  output-map column index of the window flagged by enable.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All counters go to 0.
  - enable, frame_done, out_row and out_col go to 0.
  - Reset mid-frame abandons the frame. No frame_done is produced.
- States:
  - IDLE: start=1 -> STREAM. Counters are cleared on entry.
  - STREAM: pix_ready=1. A pixel is accepted when pix_valid & pix_ready.
    - Acceptance of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) -> DONE.
    - No acceptance: counters hold (stall); enable=0 next cycle.
  - DONE: lasts exactly 1 cycle with frame_done=1, then -> IDLE.
- Ignored inputs:
  - pix_valid in IDLE/DONE is not accepted and not counted.
  - start in STREAM/DONE is ignored.
- Counters:
  - in_col and in_row give the position of the pixel being accepted.
  - in_col wraps from IMAGE_WIDTH-1 to 0 and increments in_row.
  - row_phase and col_phase count 0..STRIDE-1. They are enabled once in_row >= KERNEL_SIZE-1 and in_col >= KERNEL_SIZE-1 respectively. col_phase resets at each row start.
  - No division or modulo operators.
- Window-valid condition for accepted pixel (r,c):
  - r >= KERNEL_SIZE-1 and c >= KERNEL_SIZE-1, and
  - (r-KERNEL_SIZE+1) % STRIDE == 0 and (c-KERNEL_SIZE+1) % STRIDE == 0, implemented via the phase counters.
- Output timing:
  - enable, out_row and out_col are registered, with latency 1 cycle from the accepting edge.
  - out_row = (r-KERNEL_SIZE+1)/STRIDE and out_col likewise, held in dedicated output counters.
  - out_row and out_col hold their last values when enable=0.
- Output map size:
  - OUT_W = (IMAGE_WIDTH-KERNEL_SIZE)/STRIDE+1.
  - OUT_H = (IMAGE_HEIGHT-KERNEL_SIZE)/STRIDE+1.
  - Exactly OUT_W*OUT_H enables per frame.
- Last-pixel overlap: if the last pixel completes a window, its enable and frame_done assert in the same cycle.
- Back-to-back frames:
  - start can be asserted in the cycle after DONE, while IDLE.
  - Minimum gap is 1 IDLE cycle between frames.

Test Plan:
- Defaults (28x28, K=5, S=1), start, then 784 pixels with pix_valid held high:
  - exactly 576 enables;
  - first enable 1 cycle after accepting pixel (4,4) with out_row=0, out_col=0;
  - last enable with out=(23,23) in the same cycle as frame_done;
  - busy high for 785 cycles.
- W=H=8, K=3, S=2:
  - 9 enables, at input positions (2|4|6, 2|4|6);
  - out indices 0..2;
  - pixel (7,7) produces frame_done with enable=0.
- Defaults with pseudo-random pix_valid (~50% duty):
  - enable count is still 576;
  - out_row/out_col sequence is identical to the no-stall run;
  - no enable after any non-accepting cycle.
- W=10, H=6, K=3, S=1:
  - 8x4=32 enables;
  - out_col wraps 7 -> 0 with out_row incrementing.
- Protocol and reset:
  - reset asserted at pixel 300 -> all outputs 0 immediately (async), no frame_done;
  - a new start afterwards produces a correct full frame;
  - start pulsed during STREAM -> no effect on counts;
  - pix_valid in IDLE -> pix_ready=0, no enable.
